// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory responders: FSM encoding, word geometry
// and access-error causes.
package cpu_mem_pkg;

    localparam int BYTE_LANES = 4;
    localparam int WORD_BYTES = 4;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_WAIT   = 2'd1;
    localparam state_t S_ACCESS = 2'd2;
    localparam state_t S_RESP   = 2'd3;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_CAUSES   = 2;

    typedef logic [ERR_CAUSES-1:0] err_cause_t;

    // Byte address must be word aligned and fit inside a 2**word_addr_width word array.
    function automatic err_cause_t access_errors(input logic [31:0] addr,
                                                 input int unsigned word_addr_width);
        err_cause_t cause;
        cause               = '0;
        cause[ERR_MISALIGN] = |addr[1:0];
        cause[ERR_RANGE]    = |(addr >> (word_addr_width + 2));
        return cause;
    endfunction

endpackage

// File: rtl/cpu_dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a registered
// read port. Contents are not initialised.
module cpu_dmem_array
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [BYTE_LANES-1:0] we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    // NOTE: no reset here -- a storage array is never reset, only its control
    // path is, so reset cannot corrupt or stall memory contents.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cpu_dmem_responder.sv
// Data-memory responder for the CPU datapath: one outstanding request, fixed
// wait states, word load / byte-strobed store, misaligned and out-of-range flagging.
module cpu_dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  write_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [BYTE_LANES-1:0] wstrb_q;

    err_cause_t            err_cause;
    logic                  ram_en;
    logic [BYTE_LANES-1:0] ram_we;
    logic [31:0]           ram_rdata;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        err_cause = access_errors(addr_q, ADDR_WIDTH);
        ram_en    = 1'b0;
        ram_we    = '0;
        if (state == S_ACCESS && err_cause == '0) begin
            ram_en = 1'b1;
            ram_we = write_q ? wstrb_q : '0;
        end
    end

    assign req_ready = (state == S_IDLE);

    cpu_dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q[ADDR_WIDTH+1:2]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        wstrb_q  <= req_wstrb;
                        wait_cnt <= WAIT_INIT;
                        state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) state <= S_ACCESS;
                end
                S_ACCESS: begin
                    state <= S_RESP;
                end
                S_RESP: begin
                    // First RESP cycle captures the registered array output.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= |err_cause;
                        rsp_rdata <= (write_q || (err_cause != '0)) ? 32'd0 : ram_rdata;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Directed bench for cpu_dmem_responder: one instance with two wait states and
// one with none; hand-computed expectations checked with immediate assertions.
module tb_cpu_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_ready0, req_write0;
    logic [31:0] req_addr0, req_wdata0;
    logic [3:0]  req_wstrb0;
    logic        rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int total = 0;
    int bad   = 0;

    assign rsp_ready0 = 1'b1;

    always #5 clk = ~clk;

    cpu_dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    cpu_dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called 1ns after a rising edge. Presents one request to the 2-wait-state
    // instance, scrambles the request inputs after acceptance, holds the
    // response for 'hold' cycles, then takes it.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input int hold,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~wr; req_addr = 32'h0000_0010;
        req_wdata = ~d;   req_wstrb = 4'hF;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"},   32'(lat),       32'd4);
        check({tag, ".rdata"}, rsp_rdata,      exp_rdata);
        check({tag, ".err"},   32'(rsp_err),   32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold.valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".hold.rdata"}, rsp_rdata,      exp_rdata);
            check({tag, ".hold.err"},   32'(rsp_err),   32'(exp_err));
            check({tag, ".hold.ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, ".done.ready"}, 32'(req_ready), 32'd1);
        check({tag, ".done.valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".done.rdata"}, rsp_rdata,      32'd0);
    endtask

    // Same for the zero-wait-state instance, whose rsp_ready is tied high.
    task automatic do_req0(input string tag, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rdata);
        int lat;
        req_valid0 = 1'b1; req_write0 = wr; req_addr0 = a; req_wdata0 = d; req_wstrb0 = 4'hF;
        @(posedge clk); #1;
        req_valid0 = 1'b0; req_addr0 = 32'h0; req_wdata0 = 32'h0;
        lat = 0;
        while (!rsp_valid0 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"},   32'(lat),      32'd2);
        check({tag, ".rdata"}, rsp_rdata0,    exp_rdata);
        check({tag, ".err"},   32'(rsp_err0), 32'd0);
        @(posedge clk); #1;
        check({tag, ".ready"}, 32'(req_ready0), 32'd1);
        check({tag, ".valid"}, 32'(rsp_valid0), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0; req_write  = 1'b0; req_addr  = '0; req_wdata  = '0; req_wstrb  = '0;
        rsp_ready  = 1'b0;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_wstrb0 = '0;
        #2;
        check("reset.req_ready", 32'(req_ready), 32'd1);
        check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset.rsp_rdata", rsp_rdata,      32'd0);
        check("reset.rsp_err",   32'(rsp_err),   32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-word store then load with latency checks.
        do_req("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'd0, 1'b0);
        do_req("ld10", 1'b0, 32'h10, 32'h0,        4'h0, 0, 32'hDEAD_BEEF, 1'b0);

        // Byte strobes: lanes 0 and 2 overwritten.
        do_req("st20a", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, 32'd0, 1'b0);
        do_req("st20b", 1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, 0, 32'd0, 1'b0);
        do_req("ld20",  1'b0, 32'h20, 32'h0,         4'h0, 0, 32'h11BB_33DD, 1'b0);

        // Zero-strobe store is a no-op that still responds.
        do_req("st20z", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 0, 32'd0, 1'b0);
        do_req("ld20z", 1'b0, 32'h20, 32'h0,         4'h0, 0, 32'h11BB_33DD, 1'b0);

        // Errors: 0x1000 aliases word 0 if the range check were missing.
        do_req("st00",  1'b1, 32'h0,    32'h0,         4'hF, 0, 32'd0, 1'b0);
        do_req("ld13",  1'b0, 32'h13,   32'h0,         4'h0, 0, 32'd0, 1'b1);
        do_req("st1000",1'b1, 32'h1000, 32'h1234_5678, 4'hF, 0, 32'd0, 1'b1);
        do_req("ld00",  1'b0, 32'h0,    32'h0,         4'h0, 0, 32'd0, 1'b0);
        do_req("ld3fc", 1'b0, 32'h8000_0000, 32'h0,    4'h0, 0, 32'd0, 1'b1);

        // Backpressure in RESP for five cycles.
        do_req("bp",    1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDEAD_BEEF, 1'b0);

        // Reset during WAIT aborts a pending store.
        do_req("st40",  1'b1, 32'h40, 32'h0, 4'hF, 0, 32'd0, 1'b0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h55; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.req_ready", 32'(req_ready), 32'd1);
        check("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid.rsp_rdata", rsp_rdata,      32'd0);
        check("rst_mid.rsp_err",   32'(rsp_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req("ld40",  1'b0, 32'h40, 32'h0, 4'h0, 0, 32'd0, 1'b0);

        // Zero wait states, rsp_ready tied high.
        do_req0("w0.st8", 1'b1, 32'h8, 32'hCAFE_F00D, 32'd0);
        do_req0("w0.ld8", 1'b0, 32'h8, 32'h0,         32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_dmem_responder.md
Name: cpu_dmem_responder

Overview:
Data-memory responder serving the load/store requests issued by the CPU datapath; it is the memory end of the datapath's mem_read/mem_write interface. It accepts one request at a time over a valid/ready handshake, applies a fixed programmable wait-state count, and performs a word read or a byte-strobed write on an internal word array. It returns read data or write completion over a second valid/ready handshake. Misaligned and out-of-range accesses are flagged, not executed.

Parameters:
ADDR_WIDTH, 10, word-address width; array depth = 2**ADDR_WIDTH words of 32 bits
WAIT_CYCLES, 2, wait states between request acceptance and array access (0..15 legal)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  datapath presents a request
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_wstrb  in  4  store byte enables, bit i enables byte lane i (bits 8i+7:8i)
rsp_valid  out  1  response available
rsp_ready  in  1  datapath takes the response
rsp_rdata  out  32  load data; 0 for stores and errors
rsp_err  out  1  access was misaligned or out of range

Behaviour:
- Reset (async assert, sync release): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Array contents are not cleared by reset.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write, addr, wdata and wstrb, and load the counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT: req_ready=0. Decrement the counter each cycle. Go to ACCESS when the counter reaches 1.
- ACCESS (one cycle): evaluate errors.
  - misaligned = addr[1:0]!=0
  - out_of_range = any bit of addr[31:ADDR_WIDTH+2] set
  - On error: no array write; rsp_rdata=0, rsp_err=1.
  - On load: rsp_rdata = array[addr[ADDR_WIDTH+1:2]], registered into the response.
  - On store: write the enabled lanes only; rsp_rdata=0. wstrb=0 is a legal no-op store that still responds.
  - Next state RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready. When rsp_valid&&rsp_ready, go to IDLE, clearing rsp_valid, rsp_rdata and rsp_err.
- Latency: request accepted at edge T gives rsp_valid high after edge T+WAIT_CYCLES+2 (2 cycles when WAIT_CYCLES=0).
- Throughput is one outstanding request. req_ready is 0 in WAIT, ACCESS and RESP, so no back-to-back accept occurs in the handshake cycle.
- Request inputs are ignored outside IDLE; changing them after acceptance has no effect.
- Reset mid-operation aborts immediately. A store not yet in ACCESS is never written. A store whose ACCESS edge completed stays written.
- A load from a never-written in-range address returns the array's power-up value. The bench treats that value as unknown.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - the state enum (IDLE, WAIT, ACCESS, RESP)
  - the byte-lane count constant (4)
  - the word size in bytes
  - the MISALIGN/RANGE error cause constants, reused later by an instruction-fetch responder
- One sub-module, cpu_dmem_array: single-port synchronous word RAM with a 4-bit byte write enable and a registered read. It has no reset.

Test Plan:
- WAIT_CYCLES=2: store 0xDEADBEEF to 0x10 with wstrb=0xF, then load 0x10. Required: rsp_rdata=0xDEADBEEF, rsp_err=0, and rsp_valid rises exactly 4 cycles after each accept.
- Byte strobes: store 0x11223344 to 0x20 with wstrb=0xF, then 0xAABBCCDD with wstrb=0x5, then load. Required: 0x11BB33DD.
- Errors: load 0x13 (misaligned), then store to 0x1000 with ADDR_WIDTH=10 (out of range). Required: rsp_err=1 and rsp_rdata=0 for both; a reload of 0x0 shows no change.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. Required: rsp_valid, rsp_rdata and rsp_err stay stable and req_ready=0 throughout. After release, req_ready=1 on the next cycle.
- Reset mid-op: accept a store of 0x55 to 0x40 while address 0x40 holds 0x0, then assert rst_n=0 in WAIT. Required: outputs return to reset values asynchronously, and a later load of 0x40 returns 0x0.
- WAIT_CYCLES=0: load. Required: rsp_valid 2 cycles after accept. With rsp_ready tied to 1, req_ready reasserts in the following cycle.
